// File: rtl/spi_fpga_slave_pkg.sv
// Shared definitions for the SPI slave: FSM states, bit-order constants and
// helpers that derive the sample/shift edge from the SPI mode.
package spi_fpga_slave_pkg;

    // Bit-order encoding, identical to the one used by the SPI master.
    localparam logic BIT_SEQ_MSB_FIRST = 1'b1;
    localparam logic BIT_SEQ_LSB_FIRST = 1'b0;

    typedef enum logic [0:0] {
        StIdle,
        StActive
    } state_e;

    function automatic logic leading_is_rise(input logic cpol);
        return !cpol;
    endfunction

    // Sampling happens on the leading edge for CPHA=0 and on the trailing edge for CPHA=1.
    // The result reduces to "sample on rising SCLK" exactly when CPOL equals CPHA.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return leading_is_rise(cpol) ^ cpha;
    endfunction

endpackage

// File: rtl/spi_fpga_slave_if.sv
// Bus bundle between the SPI slave and its environment: the four SPI wires plus
// the fabric-side TX/RX word interface.
interface spi_fpga_slave_if #(
    parameter int unsigned PACK_LENGTH = 8
);
    logic                   cs;
    logic                   sclk;
    logic                   mosi;
    logic                   miso;
    logic                   miso_en;
    logic [PACK_LENGTH-1:0] tx_data;
    logic                   tx_load;
    logic                   tx_ready;
    logic [PACK_LENGTH-1:0] receive_data;
    logic                   receive_valid;

    modport slave (
        input  cs, sclk, mosi, tx_data, tx_load,
        output miso, miso_en, tx_ready, receive_data, receive_valid
    );

    modport master (
        output cs, sclk, mosi, tx_data, tx_load,
        input  miso, miso_en, tx_ready, receive_data, receive_valid
    );
endinterface

// File: rtl/spi_fpga_input_sync.sv
// Two-flop synchronizer for an asynchronous input with a third stage that
// yields single-cycle rise/fall pulses of the synchronized level.
module spi_fpga_input_sync #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {3{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign dout = sync_q[1];
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_fpga_slave.sv
// Oversampled SPI slave: full-duplex PACK_LENGTH-bit words, any CPOL/CPHA mode,
// TX holding register on the fabric side, back-to-back words while CS stays low.
module spi_fpga_slave
    import spi_fpga_slave_pkg::*;
#(
    parameter int unsigned PACK_LENGTH                = 8,
    parameter logic        CPOL                       = 1'b0,
    parameter logic        CPHA                       = 1'b0,
    parameter logic        PACK_BIT_SEQUENCE_TRANSMIT = BIT_SEQ_MSB_FIRST,
    parameter logic        PACK_BIT_SEQUENCE_RECEIVE  = BIT_SEQ_MSB_FIRST
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_fpga_slave_if.slave    bus
);
    localparam int unsigned CNT_W       = $clog2(PACK_LENGTH + 1);
    localparam logic        SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    typedef logic [PACK_LENGTH-1:0] word_t;

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_fpga_input_sync #(.RESET_VALUE(CPOL)) u_sync_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.sclk),
        .dout (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_fpga_input_sync #(.RESET_VALUE(1'b1)) u_sync_cs (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.cs),
        .dout (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_fpga_input_sync #(.RESET_VALUE(1'b0)) u_sync_mosi (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.mosi),
        .dout (mosi_s),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    // Edge strobes carry all the timing; the synchronized levels of SCLK/CS are not needed.
    logic unused_sync;
    assign unused_sync = ^{sclk_s, cs_s, mosi_rise, mosi_fall};

    logic sample_edge, shift_edge;
    assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

    function automatic logic tx_first_bit(input word_t w);
        return (PACK_BIT_SEQUENCE_TRANSMIT == BIT_SEQ_MSB_FIRST) ? w[PACK_LENGTH-1] : w[0];
    endfunction

    function automatic word_t tx_advance(input word_t w);
        return (PACK_BIT_SEQUENCE_TRANSMIT == BIT_SEQ_MSB_FIRST) ? (w << 1) : (w >> 1);
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    word_t            tx_shift_q, tx_shift_d;
    word_t            rx_shift_q, rx_shift_d;
    word_t            hold_q, hold_d;
    logic             tx_ready_q, tx_ready_d;
    logic             miso_q, miso_d;
    logic             miso_en_q, miso_en_d;
    word_t            rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             skip_q, skip_d;

    logic             load_accept;
    logic             reload;
    word_t            reload_word;
    word_t            rx_next;
    logic [CNT_W-1:0] cnt_inc;

    assign load_accept = bus.tx_load & tx_ready_q;
    assign reload_word = tx_ready_q ? '0 : hold_q;
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign rx_next     = (PACK_BIT_SEQUENCE_RECEIVE == BIT_SEQ_MSB_FIRST) ?
                         {rx_shift_q[PACK_LENGTH-2:0], mosi_s} :
                         {mosi_s, rx_shift_q[PACK_LENGTH-1:1]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        miso_d     = miso_q;
        miso_en_d  = miso_en_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        skip_d     = skip_q;
        reload     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d   = StActive;
                    reload    = 1'b1;
                    cnt_d     = '0;
                    miso_en_d = 1'b1;
                    skip_d    = 1'b0;
                    if (!CPHA) begin
                        miso_d     = tx_first_bit(reload_word);
                        tx_shift_d = tx_advance(reload_word);
                    end else begin
                        tx_shift_d = reload_word;
                    end
                end
            end
            StActive: begin
                if (cs_rise) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    miso_en_d = 1'b0;
                    skip_d    = 1'b0;
                end else if (sample_edge) begin
                    rx_shift_d = rx_next;
                    if (cnt_inc == CNT_W'(PACK_LENGTH)) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
                        reload     = 1'b1;
                        // With CPHA=0 bit 0 of the next word goes out now, so the
                        // trailing edge that follows must not advance MISO again.
                        if (!CPHA) begin
                            miso_d     = tx_first_bit(reload_word);
                            tx_shift_d = tx_advance(reload_word);
                            skip_d     = 1'b1;
                        end else begin
                            tx_shift_d = reload_word;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (shift_edge) begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else begin
                        miso_d     = tx_first_bit(tx_shift_q);
                        tx_shift_d = tx_advance(tx_shift_q);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A load coinciding with a reload wins READY; the reload already took the old contents.
    always_comb begin
        hold_d     = hold_q;
        tx_ready_d = tx_ready_q;
        if (load_accept) begin
            hold_d     = bus.tx_data;
            tx_ready_d = 1'b0;
        end else if (reload) begin
            tx_ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            hold_q     <= '0;
            tx_ready_q <= 1'b1;
            miso_q     <= 1'b0;
            miso_en_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            skip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            hold_q     <= hold_d;
            tx_ready_q <= tx_ready_d;
            miso_q     <= miso_d;
            miso_en_q  <= miso_en_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            skip_q     <= skip_d;
        end
    end

    assign bus.miso          = miso_q;
    assign bus.miso_en       = miso_en_q;
    assign bus.tx_ready      = tx_ready_q;
    assign bus.receive_data  = rx_data_q;
    assign bus.receive_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_fpga_slave.sv
// Bench for spi_fpga_slave: four instances (one per SPI mode, mode 2 receiving
// LSB-first) driven by a behavioural SPI master, vector table plus corner sequences.
module tb_spi_fpga_slave;
    localparam int HALF = 80;  // SCLK half period = 8 system clocks

    logic clk;
    logic rst_n;
    int   sel;
    logic m_cs, m_sclk, m_mosi, m_miso;
    logic [7:0] s_tx_data;
    logic s_tx_load;

    logic [3:0] miso_a, miso_en_a, ready_a, valid_a;
    logic [7:0] rdata_a [4];
    int         vcnt [4];

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam logic P_CPOL = (g >= 2);
        localparam logic P_CPHA = (g == 1 || g == 3);
        localparam logic P_RXSEQ = (g == 2) ? 1'b0 : 1'b1;

        spi_fpga_slave_if #(.PACK_LENGTH(8)) bus ();

        assign bus.cs      = (sel == g) ? m_cs : 1'b1;
        assign bus.sclk    = (sel == g) ? m_sclk : P_CPOL;
        assign bus.mosi    = m_mosi;
        assign bus.tx_data = s_tx_data;
        assign bus.tx_load = s_tx_load && (sel == g);

        assign miso_a[g]    = bus.miso;
        assign miso_en_a[g] = bus.miso_en;
        assign ready_a[g]   = bus.tx_ready;
        assign valid_a[g]   = bus.receive_valid;
        assign rdata_a[g]   = bus.receive_data;

        spi_fpga_slave #(
            .PACK_LENGTH               (8),
            .CPOL                      (P_CPOL),
            .CPHA                      (P_CPHA),
            .PACK_BIT_SEQUENCE_TRANSMIT(1'b1),
            .PACK_BIT_SEQUENCE_RECEIVE (P_RXSEQ)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );
    end

    assign m_miso = miso_a[sel];

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (valid_a[k]) vcnt[k] <= vcnt[k] + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic select_dut(input int s);
        @(negedge clk);
        sel    = s;
        m_cs   = 1'b1;
        m_sclk = (s >= 2);
        repeat (6) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] d);
        @(negedge clk);
        s_tx_data = d;
        s_tx_load = 1'b1;
        @(negedge clk);
        s_tx_load = 1'b0;
    endtask

    // Master is always MSB-first; it shifts out mtx[nbits-1:0] and collects nbits of MISO.
    task automatic master_frame(input int nbits, input logic [15:0] mtx, output logic [15:0] mrx);
        logic cpol, cpha;
        cpol   = (sel >= 2);
        cpha   = (sel == 1 || sel == 3);
        mrx    = '0;
        m_sclk = cpol;
        m_cs   = 1'b0;
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                m_mosi = mtx[nbits-1-i];
                #HALF;
                m_sclk = ~cpol;
                mrx    = {mrx[14:0], m_miso};
                #HALF;
                m_sclk = cpol;
            end else begin
                m_sclk = ~cpol;
                m_mosi = mtx[nbits-1-i];
                #HALF;
                m_sclk = cpol;
                mrx    = {mrx[14:0], m_miso};
                #HALF;
            end
        end
        #HALF;
        m_cs   = 1'b1;
        m_mosi = 1'b0;
    endtask

    typedef struct {
        int         dut;
        logic [7:0] m_tx;
        logic [7:0] s_tx;
        logic [7:0] exp_s_rx;
        logic [7:0] exp_m_rx;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] mrx;
        int          v0;
        logic        dropped;

        total = 0;
        bad   = 0;
        for (int k = 0; k < 4; k++) vcnt[k] = 0;

        vecs[0] = '{0, 8'hEA, 8'hA5, 8'hEA, 8'hA5};
        vecs[1] = '{0, 8'h3C, 8'hC3, 8'h3C, 8'hC3};
        vecs[2] = '{1, 8'h3C, 8'hC3, 8'h3C, 8'hC3};
        vecs[3] = '{2, 8'h3C, 8'hC3, 8'h3C, 8'hC3};
        vecs[4] = '{2, 8'hEA, 8'hA5, 8'h57, 8'hA5};
        vecs[5] = '{3, 8'h3C, 8'hC3, 8'h3C, 8'hC3};
        vecs[6] = '{3, 8'hEA, 8'h5A, 8'hEA, 8'h5A};
        vecs[7] = '{1, 8'h96, 8'h0F, 8'h96, 8'h0F};

        sel       = 0;
        m_cs      = 1'b1;
        m_sclk    = 1'b0;
        m_mosi    = 1'b0;
        s_tx_data = '0;
        s_tx_load = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);

        check("reset miso", {31'd0, miso_a[0]}, 32'd0);
        check("reset miso_en", {31'd0, miso_en_a[0]}, 32'd0);
        check("reset tx_ready", {31'd0, ready_a[0]}, 32'd1);
        check("reset receive_data", {24'd0, rdata_a[0]}, 32'd0);
        check("reset receive_valid", {31'd0, valid_a[0]}, 32'd0);

        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            select_dut(vecs[i].dut);
            load(vecs[i].s_tx);
            check("ready drops after load", {31'd0, ready_a[sel]}, 32'd0);
            v0 = vcnt[sel];
            master_frame(8, {8'h00, vecs[i].m_tx}, mrx);
            repeat (10) @(negedge clk);
            check("vector slave rx", {24'd0, rdata_a[sel]}, {24'd0, vecs[i].exp_s_rx});
            check("vector master rx", {16'd0, mrx}, {24'd0, vecs[i].exp_m_rx});
            check("vector valid count", vcnt[sel] - v0, 32'd1);
            check("vector ready after frame", {31'd0, ready_a[sel]}, 32'd1);
        end

        // Aborted frame: partial word discarded, data stays from the last complete word.
        select_dut(0);
        v0 = vcnt[0];
        master_frame(5, 16'h0015, mrx);
        repeat (10) @(negedge clk);
        check("abort no valid", vcnt[0] - v0, 32'd0);
        check("abort data held", {24'd0, rdata_a[0]}, 32'h3C);
        check("abort miso_en low", {31'd0, miso_en_a[0]}, 32'd0);
        master_frame(8, 16'h0096, mrx);
        repeat (10) @(negedge clk);
        check("after abort slave rx", {24'd0, rdata_a[0]}, 32'h96);
        check("after abort master rx", {16'd0, mrx}, 32'h00);
        check("after abort valid", vcnt[0] - v0, 32'd1);

        // Two back-to-back words, second word loaded while the first is shifting.
        load(8'h11);
        v0 = vcnt[0];
        fork
            master_frame(16, 16'hABCD, mrx);
            begin
                #(4 * HALF);
                load(8'h22);
            end
        join
        repeat (10) @(negedge clk);
        check("two-word master rx", {16'd0, mrx}, 32'h1122);
        check("two-word slave rx", {24'd0, rdata_a[0]}, 32'hCD);
        check("two-word valid count", vcnt[0] - v0, 32'd2);

        dropped = 1'b0;
        fork
            master_frame(8, 16'h0081, mrx);
            repeat (160) @(negedge clk) if (!ready_a[0]) dropped = 1'b1;
        join
        repeat (10) @(negedge clk);
        check("empty hold master rx", {16'd0, mrx}, 32'h00);
        check("empty hold ready stays", {31'd0, dropped}, 32'd0);
        check("empty hold slave rx", {24'd0, rdata_a[0]}, 32'h81);

        // Load while not ready is ignored.
        load(8'h77);
        load(8'h88);
        master_frame(8, 16'h000F, mrx);
        repeat (10) @(negedge clk);
        check("ignored load master rx", {16'd0, mrx}, 32'h77);
        check("ignored load slave rx", {24'd0, rdata_a[0]}, 32'h0F);

        // Asynchronous reset in the middle of a frame.
        load(8'h44);
        fork
            master_frame(8, 16'h00FF, mrx);
            begin
                #(4 * HALF + 3);
                check("pre-reset miso_en", {31'd0, miso_en_a[0]}, 32'd1);
                rst_n = 1'b0;
                #1;
                check("mid reset miso", {31'd0, miso_a[0]}, 32'd0);
                check("mid reset miso_en", {31'd0, miso_en_a[0]}, 32'd0);
                check("mid reset tx_ready", {31'd0, ready_a[0]}, 32'd1);
                check("mid reset receive_data", {24'd0, rdata_a[0]}, 32'd0);
                check("mid reset receive_valid", {31'd0, valid_a[0]}, 32'd0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (10) @(negedge clk);
        load(8'h3C);
        v0 = vcnt[0];
        master_frame(8, 16'h005A, mrx);
        repeat (10) @(negedge clk);
        check("post reset slave rx", {24'd0, rdata_a[0]}, 32'h5A);
        check("post reset master rx", {16'd0, mrx}, 32'h3C);
        check("post reset valid", vcnt[0] - v0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
